// File: rtl/eth_ctrl_pkg.sv
// Shared definitions for the Ethernet link-speed controller.
//   speed_t    : MAC speed encoding driven to the GMII-RGMII converter
//   state_t    : controller FSM states (the MDIO phases are reported by mdio_master)
//   MDIO_*     : clause-22 start and read-opcode fields
//   STAT_*     : bit positions in the PHY status register
//   BIT_*      : frame bit indices where each MDIO field begins
package eth_ctrl_pkg;

  typedef enum logic [1:0] {
    SPEED_10      = 2'b00,
    SPEED_100     = 2'b01,
    SPEED_1000    = 2'b10,
    SPEED_INVALID = 2'b11
  } speed_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_TA,
    ST_DATA,
    ST_DECODE,
    ST_CONV_RST
  } state_t;

  localparam logic [1:0] MDIO_START   = 2'b01;
  localparam logic [1:0] MDIO_OP_READ = 2'b10;

  localparam int STAT_LINK_BIT  = 10;
  localparam int STAT_SPEED_MSB = 15;
  localparam int STAT_SPEED_LSB = 14;

  // 64-bit frame: 32 preamble, 14 command bits, 2 turnaround, 16 data
  localparam logic [5:0] BIT_CMD_FIRST  = 6'd32;
  localparam logic [5:0] BIT_TA_FIRST   = 6'd46;
  localparam logic [5:0] BIT_DATA_FIRST = 6'd48;
  localparam logic [5:0] BIT_LAST       = 6'd63;

endpackage

// File: rtl/mdio_master.sv
// Clause-22 MDIO read engine.
//   start            : begin a read (ignored while busy)
//   phy_addr/reg_addr: captured when start is accepted
//   mdio_i           : sampled on MDC rising edges during the data bits
//   mdc/mdio_o/oe    : pad side; mdio_o only changes as MDC falls
//   busy             : high for the whole 64-bit frame
//   done             : one-cycle pulse after the last data bit; data valid then
//   phase            : which frame field is on the wire (ST_IDLE when idle)
module mdio_master
  import eth_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        peri_clock_clk,
  input  logic        peri_reset_reset_n,
  input  logic        start,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        busy,
  output logic        done,
  output logic [15:0] data,
  output state_t      phase
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       next_bit;
  logic [13:0]      cmd_sh;
  logic             half_done;

  assign next_bit  = bit_cnt + 6'd1;
  assign half_done = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      cmd_sh  <= '0;
      data    <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        div_cnt <= '0;
        mdc     <= 1'b0;
        if (start) begin
          busy    <= 1'b1;
          bit_cnt <= '0;
          cmd_sh  <= {MDIO_START, MDIO_OP_READ, phy_addr, reg_addr};
          mdio_o  <= 1'b1;          // first preamble bit
          mdio_oe <= 1'b1;
        end
      end else if (half_done) begin
        div_cnt <= '0;
        mdc     <= ~mdc;
        if (!mdc) begin
          // rising edge: PHY data is stable here
          if (bit_cnt >= BIT_DATA_FIRST) data <= {data[14:0], mdio_i};
        end else if (bit_cnt == BIT_LAST) begin
          // falling edge closing the last data bit ends the frame
          busy    <= 1'b0;
          done    <= 1'b1;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
        end else begin
          // falling edge: present the next bit
          bit_cnt <= next_bit;
          mdio_oe <= (next_bit < BIT_TA_FIRST);
          if (next_bit >= BIT_CMD_FIRST && next_bit < BIT_TA_FIRST) begin
            mdio_o <= cmd_sh[13];
            cmd_sh <= {cmd_sh[12:0], 1'b0};
          end else begin
            mdio_o <= 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    phase = ST_IDLE;
    if (busy) begin
      if (bit_cnt < BIT_CMD_FIRST)       phase = ST_PRE;
      else if (bit_cnt < BIT_TA_FIRST)   phase = ST_CMD;
      else if (bit_cnt < BIT_DATA_FIRST) phase = ST_TA;
      else                               phase = ST_DATA;
    end
  end

endmodule

// File: rtl/eth_link_speed_ctrl.sv
// Polls the PHY status register over MDIO, debounces link/speed and sequences
// the GMII-RGMII converter (speed select + reset pulse) on applied changes.
//   poll_en            : enables the periodic poll timer
//   phy_addr           : PHY address for each read
//   mdio_i/mdc/mdio_o/mdio_oe : MDIO pads
//   mac_speed          : 00=10M 01=100M 10=1000M to the converter
//   gmii_rst_n         : converter reset, held low while link is down
//   link_up            : debounced link state
//   speed_chg          : one-cycle pulse as the converter leaves reset
//   busy               : MDIO frame in progress
module eth_link_speed_ctrl
  import eth_ctrl_pkg::*;
#(
  parameter int         CLK_DIV     = 25,
  parameter int         POLL_CYCLES = 5000000,
  parameter logic [4:0] STAT_REG    = 5'h11,
  parameter int         RST_CYCLES  = 256
) (
  input  logic       peri_clock_clk,
  input  logic       peri_reset_reset_n,
  input  logic       poll_en,
  input  logic [4:0] phy_addr,
  input  logic       mdio_i,
  output logic       mdc,
  output logic       mdio_o,
  output logic       mdio_oe,
  output logic [1:0] mac_speed,
  output logic       gmii_rst_n,
  output logic       link_up,
  output logic       speed_chg,
  output logic       busy
);

  localparam int TMR_W = $clog2(POLL_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  state_t           state;
  state_t           mm_phase;
  logic             mm_done;
  logic [15:0]      mm_data;
  logic [TMR_W-1:0] timer;
  logic [RST_W-1:0] rst_cnt;
  logic             poll_fire;
  logic             rd_link;
  logic [1:0]       rd_speed;
  logic [2:0]       hist;       // last valid {link, speed}
  logic             hist_vld;
  logic             agree;
  logic             unused_stat_bits;

  // Free-running while enabled; a tick landing outside IDLE is simply skipped.
  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n)  timer <= '0;
    else if (poll_en)         timer <= (timer == TMR_W'(POLL_CYCLES - 1)) ? '0 : timer + 1'b1;
  end

  assign poll_fire = poll_en && (timer == TMR_W'(POLL_CYCLES - 1)) && (state == ST_IDLE);

  mdio_master #(.CLK_DIV(CLK_DIV)) u_mdio (
    .peri_clock_clk     (peri_clock_clk),
    .peri_reset_reset_n (peri_reset_reset_n),
    .start              (poll_fire),
    .phy_addr           (phy_addr),
    .reg_addr           (STAT_REG),
    .mdio_i             (mdio_i),
    .mdc                (mdc),
    .mdio_o             (mdio_o),
    .mdio_oe            (mdio_oe),
    .busy               (busy),
    .done               (mm_done),
    .data               (mm_data),
    .phase              (mm_phase)
  );

  assign rd_link  = mm_data[STAT_LINK_BIT];
  assign rd_speed = mm_data[STAT_SPEED_MSB:STAT_SPEED_LSB];
  assign agree    = hist_vld && (hist == {rd_link, rd_speed});
  // Remaining status bits carry nothing this block acts on.
  assign unused_stat_bits = ^{mm_data[13:11], mm_data[9:0]};

  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) begin
      state      <= ST_IDLE;
      mac_speed  <= SPEED_1000;
      gmii_rst_n <= 1'b0;
      link_up    <= 1'b0;
      speed_chg  <= 1'b0;
      hist       <= '0;
      hist_vld   <= 1'b0;
      rst_cnt    <= '0;
    end else begin
      speed_chg <= 1'b0;
      unique case (state)
        ST_IDLE: if (poll_fire) state <= ST_PRE;
        ST_PRE, ST_CMD, ST_TA, ST_DATA: begin
          // track the engine's field so state mirrors the wire
          if (mm_done)                    state <= ST_DECODE;
          else if (mm_phase != ST_IDLE)   state <= mm_phase;
        end
        ST_DECODE: begin
          state <= ST_IDLE;
          if (rd_speed != SPEED_INVALID) begin
            hist     <= {rd_link, rd_speed};
            hist_vld <= 1'b1;
            if (agree && rd_link && (!link_up || rd_speed != mac_speed)) begin
              mac_speed  <= rd_speed;
              link_up    <= 1'b1;
              gmii_rst_n <= 1'b0;
              rst_cnt    <= '0;
              state      <= ST_CONV_RST;
            end else if (agree && !rd_link && link_up) begin
              // link lost: park the converter in reset, keep the old speed
              link_up    <= 1'b0;
              gmii_rst_n <= 1'b0;
            end
          end
        end
        ST_CONV_RST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            gmii_rst_n <= 1'b1;
            speed_chg  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_link_speed_ctrl.sv
module tb_eth_link_speed_ctrl;

  localparam int         CLK_DIV = 2;
  localparam int         POLL    = 700;
  localparam int         RSTC    = 256;
  localparam logic [4:0] STAT    = 5'h11;
  localparam int         BUSY_LEN = 128 * CLK_DIV;
  localparam logic [63:0] OE_EXP = {{46{1'b1}}, 18'h0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_en = 1'b0;
  logic [4:0] phy_addr = 5'd0;
  logic       mdio_i = 1'b1;
  logic       mdc, mdio_o, mdio_oe, gmii_rst_n, link_up, speed_chg, busy;
  logic [1:0] mac_speed;

  always #5 clk = ~clk;

  eth_link_speed_ctrl #(
    .CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .STAT_REG(STAT), .RST_CYCLES(RSTC)
  ) dut (
    .peri_clock_clk     (clk),
    .peri_reset_reset_n (rst_n),
    .poll_en            (poll_en),
    .phy_addr           (phy_addr),
    .mdio_i             (mdio_i),
    .mdc                (mdc),
    .mdio_o             (mdio_o),
    .mdio_oe            (mdio_oe),
    .mac_speed          (mac_speed),
    .gmii_rst_n         (gmii_rst_n),
    .link_up            (link_up),
    .speed_chg          (speed_chg),
    .busy               (busy)
  );

  int tests = 0;
  int fails = 0;

  // PHY model / frame capture, evaluated mid-cycle
  logic [15:0] phy_resp = 16'h0;
  logic [63:0] fr_o = '0, fr_oe = '0;
  int          fr_bits = 0;
  int          bitn = 0;
  logic        prev_mdc = 1'b0;
  int          mdc_idle_viol = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!busy) begin
        if (mdc) mdc_idle_viol++;
        bitn   = 0;
        mdio_i = 1'b1;
      end else begin
        if (mdc && !prev_mdc) begin
          if (bitn == 0) fr_bits = 0;
          fr_o[63-bitn]  = mdio_o;
          fr_oe[63-bitn] = mdio_oe;
          fr_bits++;
        end
        if (!mdc && prev_mdc) begin
          bitn++;
          if (bitn >= 48 && bitn < 64) mdio_i = phy_resp[63-bitn];
        end
      end
      prev_mdc = mdc;
    end
  end

  // Reference model: applied link/speed from the debounce rules
  bit         m_link = 1'b0;
  logic [1:0] m_speed = 2'b10;
  logic [2:0] m_prev = 3'b0;
  bit         m_prev_vld = 1'b0;

  task automatic model_read(input logic [15:0] r, output bit pulse);
    logic       l;
    logic [1:0] sp;
    pulse = 1'b0;
    l  = r[10];
    sp = r[15:14];
    if (sp == 2'b11) return;
    if (m_prev_vld && m_prev == {l, sp}) begin
      if (l && (!m_link || sp != m_speed)) begin
        m_link = 1'b1; m_speed = sp; pulse = 1'b1;
      end else if (!l && m_link) begin
        m_link = 1'b0;
      end
    end
    m_prev = {l, sp};
    m_prev_vld = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] resp, input string name, output int waited);
    int n, c, low, chg;
    bit pulse, marked, rose, aligned;
    logic [2:0]  pre;
    logic [63:0] exp_o;
    phy_resp = resp;
    phy_addr = 5'($urandom);
    n = 0;
    while (!busy && n < POLL + 20) begin step(); n++; end
    waited = n;
    tests++;
    if (!busy) begin
      fails++;
      $display("FAIL %s start: busy=0 after %0d cycles, required 1", name, n);
      return;
    end
    c = 0;
    while (busy && c < BUSY_LEN + 20) begin c++; step(); end
    tests++;
    if (c !== BUSY_LEN) begin
      fails++; $display("FAIL %s busy_len: got %0d want %0d", name, c, BUSY_LEN);
    end
    exp_o = {32'hFFFF_FFFF, 2'b01, 2'b10, phy_addr, STAT, 18'h0};
    tests++;
    if (fr_bits !== 64 || fr_oe !== OE_EXP || (fr_o & OE_EXP) !== exp_o) begin
      fails++;
      $display("FAIL %s frame: bits=%0d o=%h oe=%h want bits=64 o=%h oe=%h",
               name, fr_bits, fr_o & OE_EXP, fr_oe, exp_o, OE_EXP);
    end
    pre = {link_up, mac_speed};
    model_read(resp, pulse);
    low = 0; chg = 0; marked = 0; rose = 0; aligned = 0;
    for (int i = 0; i < RSTC + 20; i++) begin
      step();
      if (speed_chg) chg++;
      if (!marked && {link_up, mac_speed} !== pre) marked = 1;
      if (marked && !rose) begin
        if (!gmii_rst_n) low++;
        else begin rose = 1; aligned = speed_chg; end
      end
    end
    tests++;
    if (link_up !== m_link || mac_speed !== m_speed) begin
      fails++;
      $display("FAIL %s state: link=%b speed=%b want link=%b speed=%b",
               name, link_up, mac_speed, m_link, m_speed);
    end
    tests++;
    if (gmii_rst_n !== m_link) begin
      fails++; $display("FAIL %s gmii_rst_n: got %b want %b", name, gmii_rst_n, m_link);
    end
    tests++;
    if (chg !== int'(pulse)) begin
      fails++; $display("FAIL %s speed_chg count: got %0d want %0d", name, chg, int'(pulse));
    end
    if (pulse) begin
      tests++;
      if (low !== RSTC || !aligned) begin
        fails++;
        $display("FAIL %s conv_rst: low=%0d chg_at_release=%b want low=%0d chg=1",
                 name, low, aligned, RSTC);
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({mdc, mdio_o, mdio_oe, mac_speed, gmii_rst_n, link_up, speed_chg, busy} !== 9'b0_1_0_10_0_0_0_0) begin
      fails++;
      $display("FAIL reset_values: got %b want %b",
               {mdc, mdio_o, mdio_oe, mac_speed, gmii_rst_n, link_up, speed_chg, busy}, 9'b0_1_0_10_0_0_0_0);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < POLL + 50; i++) begin step(); if (busy) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL poll_disabled_idle: busy seen=1 want 0"); end
  endtask

  task automatic test_link_up_1000();
    int w;
    poll_en = 1'b1;
    do_read(16'h8400, "link_up_rd1", w);
    tests++;
    if (w !== POLL) begin fails++; $display("FAIL first_poll_latency: got %0d want %0d", w, POLL); end
    do_read(16'h8400, "link_up_rd2", w);
  endtask

  task automatic test_speed_change();
    int w;
    do_read(16'h4400, "spd100_rd1", w);
    do_read(16'h4400, "spd100_rd2", w);
  endtask

  task automatic test_disagree();
    int w;
    do_read(16'h4400, "disagree_rd1", w);
    do_read(16'h8400, "disagree_rd2", w);
  endtask

  task automatic test_invalid_and_link_down();
    int w;
    do_read(16'hC400, "invalid", w);
    do_read(16'h0000, "down_rd1", w);
    do_read(16'h0000, "down_rd2", w);
  endtask

  task automatic test_poll_disable();
    int n, c;
    bit seen, p;
    phy_resp = 16'h0000;
    n = 0;
    while (!busy && n < POLL + 20) begin step(); n++; end
    tests++;
    if (!busy) begin fails++; $display("FAIL poll_dis start: busy=0 want 1"); return; end
    poll_en = 1'b0;
    c = 0;
    while (busy && c < BUSY_LEN + 20) begin c++; step(); end
    model_read(16'h0000, p);
    tests++;
    if (busy || fr_bits !== 64) begin
      fails++; $display("FAIL poll_dis complete: busy=%b bits=%0d want 0/64", busy, fr_bits);
    end
    seen = 0;
    for (int i = 0; i < 2 * POLL; i++) begin step(); if (busy) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL poll_dis no_new: busy seen=1 want 0"); end
    tests++;
    if (link_up !== m_link) begin
      fails++; $display("FAIL poll_dis link: got %b want %b", link_up, m_link);
    end
    poll_en = 1'b1;
  endtask

  task automatic test_random();
    int w;
    logic [15:0] r;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 5))
        0: r = 16'h8400;
        1: r = 16'h4400;
        2: r = 16'h0400;
        3: r = 16'h0000;
        4: r = 16'hC400;
        default: r = 16'($urandom);
      endcase
      do_read(r, $sformatf("rand%0d_%h", i, r), w);
    end
  endtask

  task automatic test_reset_mid();
    int n, w;
    // history now holds a 1000M/link-up read; it must not survive reset
    do_read(16'h8400, "pre_rst_rd1", w);
    do_read(16'h8400, "pre_rst_rd2", w);
    phy_resp = 16'h8400;
    n = 0;
    while (bitn < 50 && n < POLL + BUSY_LEN) begin step(); n++; end
    tests++;
    if (bitn < 50) begin fails++; $display("FAIL rst_mid reach_data: bitn=%0d want >=50", bitn); return; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mdc, mdio_o, mdio_oe, mac_speed, gmii_rst_n, link_up, speed_chg, busy} !== 9'b0_1_0_10_0_0_0_0) begin
      fails++;
      $display("FAIL rst_mid outputs: got %b want %b",
               {mdc, mdio_o, mdio_oe, mac_speed, gmii_rst_n, link_up, speed_chg, busy}, 9'b0_1_0_10_0_0_0_0);
    end
    step();
    rst_n = 1'b1;
    m_link = 1'b0; m_speed = 2'b10; m_prev_vld = 1'b0;
    do_read(16'h8400, "post_rst_rd1", w);
    tests++;
    if (w !== POLL) begin fails++; $display("FAIL post_rst latency: got %0d want %0d", w, POLL); end
    do_read(16'h8400, "post_rst_rd2", w);
  endtask

  task automatic test_mdc_idle();
    tests++;
    if (mdc_idle_viol !== 0) begin
      fails++; $display("FAIL mdc_idle: %0d cycles mdc=1 while idle, want 0", mdc_idle_viol);
    end
  endtask

  initial begin
    test_reset();
    test_link_up_1000();
    test_speed_change();
    test_disagree();
    test_invalid_and_link_down();
    test_poll_disable();
    test_random();
    test_reset_mid();
    test_mdc_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
